// File: rtl/regfile_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_wr_arb_pkg
//  Brief   : Shared register-file sizing constants and the two-way
//            round-robin grant function used by the write arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package regfile_wr_arb_pkg;

  // Register-file geometry shared by the arbiter and its users
  localparam int unsigned RF_REG_NUM    = 32;
  localparam int unsigned RF_REG_ADDR_W = 5;
  localparam int unsigned RF_REG_W      = 32;

  // Two-requester round-robin grant. last_idx is the index granted most
  // recently; on a tie the other requester wins.
  function automatic logic [1:0] rr_grant(input logic [1:0] req,
                                          input logic       last_idx);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_idx ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage : regfile_wr_arb_pkg
`default_nettype wire

// File: rtl/regfile_wr_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arb2
//  Brief   : Two-input round-robin arbiter. Grants are combinational from
//            the requests and the last-granted pointer; the pointer only
//            moves when a grant is actually issued.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arb2
  import regfile_wr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Index of the requester granted most recently (1 => requester 0 wins next tie)
  logic last_q;

  // Grant is a pure function of requests and pointer, gated by enable
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      gnt_o = rr_grant(req_i, last_q);
    end
  end

  // Pointer follows every completed handshake; a grant implies a valid request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_wr_arb
//  Brief   : Register-file write-port arbiter. After reset (or a soft clear)
//            it zeroes registers 1..REG_NUM-1, one per cycle, then arbitrates
//            two write requesters round-robin onto a registered write port.
//  Rev     : 1.0  initial release
// ============================================================================
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int unsigned REG_NUM    = RF_REG_NUM,
  parameter int unsigned REG_ADDR_W = RF_REG_ADDR_W,
  parameter int unsigned REG_W      = RF_REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  valid0_i,
  input  logic [REG_ADDR_W-1:0] addr0_i,
  input  logic [REG_W-1:0]      data0_i,
  output logic                  ready0_o,
  input  logic                  valid1_i,
  input  logic [REG_ADDR_W-1:0] addr1_i,
  input  logic [REG_W-1:0]      data1_i,
  output logic                  ready1_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  init_done_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [REG_ADDR_W-1:0] CNT_FIRST = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] CNT_LAST  = REG_ADDR_W'(REG_NUM - 1);
  localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [REG_W-1:0]      ZERO_WORD = '0;

  state_e                  state_q;
  logic [REG_ADDR_W-1:0]   cnt_q;
  logic                    we_q;
  logic [REG_ADDR_W-1:0]   waddr_q;
  logic [REG_W-1:0]        wdata_q;

  logic                    arb_en;
  logic [1:0]              gnt;
  logic                    accept;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [REG_W-1:0]        sel_data;

  // Arbitration only runs in RUN; a clear request blocks it in the same cycle
  assign arb_en = (state_q == ST_RUN) && !clr_i;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i ({valid1_i, valid0_i}),
    .gnt_o (gnt)
  );

  // Steer the granted requester onto the write datapath
  always_comb begin
    accept   = |gnt;
    sel_addr = gnt[1] ? addr1_i : addr0_i;
    sel_data = gnt[1] ? data1_i : data0_i;
  end

  assign ready0_o    = gnt[0];
  assign ready1_o    = gnt[1];
  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign init_done_o = (state_q == ST_RUN);

  // CLEAR/RUN sequencer with registered write port; clr_i restarts the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_FIRST;
      we_q    <= 1'b0;
      waddr_q <= ADDR_ZERO;
      wdata_q <= ZERO_WORD;
    end else if (clr_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_FIRST;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= ZERO_WORD;
          // Last register reached: hand over to RUN without wrapping the counter
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // Address 0 is hard-wired zero: accept the request but suppress the write
          we_q <= accept && (sel_addr != ADDR_ZERO);
          if (accept) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= CNT_FIRST;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule : regfile_wr_arb
`default_nettype wire
